uart_byte_tx: RTL and testbench

Synthesizable UART transmitter with a small byte FIFO. It serializes bytes from a valid/ready push interface onto a single `txd` line as 8N1 frames, LSB first, idle-high. It is used in SoC-level simulation to drive the SoC's UART receive pin from the bench, and on FPGA as a host-side stimulus source. Its frame format and bit period match the bench-side UART monitor that samples the SoC's GPIO-mapped UART TX pin.

---
 rtl/uart_byte_tx.sv | 176 +++++++++++++++++
 tb/tb_uart_byte_tx.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: byte FIFO feeding an 8N1 UART transmitter (LSB first, idle-high).
// Optional even parity bit between data bit 7 and stop: define UART_TX_PARITY_EN.
// Every bit (start, data, parity, stop) is held for DIV clk cycles.

module uart_byte_tx #(
    parameter int unsigned DIV        = 236,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tx_valid,
    input  logic [7:0]                    tx_data,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
`ifdef UART_TX_PARITY_EN
    logic           par_bit;
`endif

    logic [7:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           empty;
    logic           full;
    logic           push;
    logic           pop;
    logic [7:0]     head;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign tx_ready   = !full;
    assign push       = tx_valid && !full;
    assign head       = mem[rd_ptr[AW-1:0]];
    assign fifo_level = wr_ptr - rd_ptr;
    assign busy       = (state != IDLE) || !empty;

    // A byte leaves the FIFO when idle, or at the very end of a stop bit so frames abut.
    assign pop = !empty && ((state == IDLE) || ((state == STOP) && (cnt == '0)));

    // FIFO storage; contents need no reset since the pointers gate every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= tx_data;
        end
    end

    // FIFO pointers, each with a wrap bit above the index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Frame sequencer: bit timing down-counter, shift register and registered txd.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            txd     <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        shreg <= head;
`ifdef UART_TX_PARITY_EN
                        par_bit <= ^head;
`endif
                        cnt   <= CNT_LOAD;
                        txd   <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        cnt     <= CNT_LOAD;
                        txd     <= shreg[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        cnt <= CNT_LOAD;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            txd   <= par_bit;
                            state <= PARITY;
`else
                            txd   <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            txd     <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (cnt == '0) begin
                        cnt   <= CNT_LOAD;
                        txd   <= 1'b1;
                        state <= STOP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt == '0) begin
                        if (pop) begin
                            shreg <= head;
`ifdef UART_TX_PARITY_EN
                            par_bit <= ^head;
`endif
                            cnt   <= CNT_LOAD;
                            txd   <= 1'b0;
                            state <= START;
                        end else begin
                            txd   <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: scoreboard bench for uart_byte_tx (DIV=236 instance plus a DIV=2 instance).
// Honours UART_TX_PARITY_EN for frame length and parity checks.

module tb_uart_byte_tx;

    localparam int DIV_A = 236;
    localparam int DIV_B = 2;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME_A = NB * DIV_A;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b0, valid_a = 1'b0;
    logic [7:0] data_a = '0;
    logic       ready_a, txd_a, busy_a;
    logic [2:0] level_a;

    logic       rst_b = 1'b0, valid_b = 1'b0;
    logic [7:0] data_b = '0;
    logic       ready_b, txd_b, busy_b;
    logic [2:0] level_b;

    uart_byte_tx #(.DIV(DIV_A), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_a), .tx_valid(valid_a), .tx_data(data_a),
        .tx_ready(ready_a), .txd(txd_a), .busy(busy_a), .fifo_level(level_a)
    );

    uart_byte_tx #(.DIV(DIV_B), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_b), .tx_valid(valid_b), .tx_data(data_b),
        .tx_ready(ready_b), .txd(txd_b), .busy(busy_b), .fifo_level(level_b)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests  = 0;
    int failed = 0;

    // scoreboard: expected bytes pushed at stimulus, decoded frames pushed by the monitor
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_byte[$];
    int unsigned rx_start[$];
    bit          rx_ok[$];
    bit          rx_par[$];

    // txd_a frame decoder: every cycle of each bit must equal the bit's first sample
    int          m_pos = -1;
    int unsigned m_t0 = 0;
    logic [10:0] m_bits = '0;
    bit          m_clean = 1'b0;
    bit          m_par_ok;
    always @(negedge clk) begin
        if (!rst_a) begin
            m_pos = -1;
        end else begin
            if (m_pos < 0 && txd_a === 1'b0) begin
                m_pos   = 0;
                m_t0    = cyc;
                m_clean = 1'b1;
            end
            if (m_pos >= 0) begin
                if (m_pos % DIV_A == 0) m_bits[m_pos / DIV_A] = txd_a;
                else if (txd_a !== m_bits[m_pos / DIV_A]) m_clean = 1'b0;
                m_pos++;
                if (m_pos == FRAME_A) begin
                    m_par_ok = 1'b1;
`ifdef UART_TX_PARITY_EN
                    m_par_ok = (m_bits[9] === ^m_bits[8:1]);
`endif
                    rx_byte.push_back(m_bits[8:1]);
                    rx_start.push_back(m_t0);
                    rx_par.push_back(m_bits[9]);
                    rx_ok.push_back(m_clean && m_bits[0] === 1'b0 && m_bits[NB-1] === 1'b1 && m_par_ok);
                    m_pos = -1;
                end
            end
        end
    end

    task automatic offer_a(input logic [7:0] d, input bit scored);
        @(negedge clk);
        valid_a = 1'b1;
        data_a  = d;
        if (scored) exp_q.push_back(d);
    endtask

    task automatic release_a();
        @(negedge clk);
        valid_a = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, output bit timeout);
        int k = 0;
        while (rx_byte.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        timeout = (rx_byte.size() < n);
    endtask

    task automatic wait_idle_a();
        int k = 0;
        while (busy_a !== 1'b0 && k < 8 * FRAME_A) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (txd_a !== 1'b1) begin failed++; $display("FAIL reset_txd: got %b expected 1", txd_a); end
        tests++; if (ready_a !== 1'b1) begin failed++; $display("FAIL reset_ready: got %b expected 1", ready_a); end
        tests++; if (busy_a !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        tests++; if (level_a !== 3'd0) begin failed++; $display("FAIL reset_level: got %0d expected 0", level_a); end
        tests++; if (txd_b !== 1'b1) begin failed++; $display("FAIL reset_txd_b: got %b expected 1", txd_b); end
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int unsigned s;
        int k;
        bit to;
        logic [7:0] e, r;
        bit ok;
        offer_a(8'h55, 1'b1);
        release_a();
        tests++; if (txd_a !== 1'b1) begin failed++; $display("FAIL single_txd_accept: got %b expected 1", txd_a); end
        tests++; if (level_a !== 3'd1) begin failed++; $display("FAIL single_level_accept: got %0d expected 1", level_a); end
        @(negedge clk);
        tests++; if (txd_a !== 1'b0) begin failed++; $display("FAIL single_start_edge: got %b expected 0", txd_a); end
        tests++; if (level_a !== 3'd0) begin failed++; $display("FAIL single_level_pop: got %0d expected 0", level_a); end
        s = cyc;
        k = 0;
        while (busy_a !== 1'b0 && k < 3 * FRAME_A) begin
            @(negedge clk);
            k++;
        end
        tests++; if (cyc - s !== FRAME_A) begin failed++; $display("FAIL single_busy_drop: got %0d cycles expected %0d", cyc - s, FRAME_A); end
        wait_rx(1, 2 * FRAME_A, to);
        tests++; if (to) begin failed++; $display("FAIL single_timeout: got 0 frames expected 1"); end
        while (!to && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            r = rx_byte.pop_front();
            ok = rx_ok.pop_front();
            void'(rx_par.pop_front());
            tests++; if (r !== e || !ok) begin failed++; $display("FAIL single_byte: got %02h ok=%0d expected %02h ok=1", r, ok, e); end
            tests++; if (rx_start.pop_front() !== s) begin failed++; $display("FAIL single_start_time: expected start at cycle %0d", s); end
        end
        exp_q.delete();
        wait_idle_a();
    endtask

    task automatic test_min_div();
        logic [10:0] fb;
        fb = '1;
        fb[0] = 1'b0;
        fb[8:1] = 8'h81;
`ifdef UART_TX_PARITY_EN
        fb[9] = ^fb[8:1];
`endif
        @(negedge clk);
        valid_b = 1'b1;
        data_b  = 8'h81;
        @(negedge clk);
        valid_b = 1'b0;
        for (int j = 0; j < 2 * NB; j++) begin
            @(negedge clk);
            tests++;
            if (txd_b !== fb[j / 2]) begin failed++; $display("FAIL min_div_bit: cycle %0d got %b expected %b", j, txd_b, fb[j / 2]); end
        end
        @(negedge clk);
        tests++; if (txd_b !== 1'b1 || busy_b !== 1'b0) begin failed++; $display("FAIL min_div_end: got txd=%b busy=%b expected txd=1 busy=0", txd_b, busy_b); end
    endtask

    task automatic test_back_to_back();
        int unsigned s1;
        int k;
        bit to;
        logic [7:0] e, r;
        bit ok;
        offer_a(8'hA5, 1'b1);
        offer_a(8'h3C, 1'b1);
        release_a();
        s1 = cyc;
        tests++; if (txd_a !== 1'b0) begin failed++; $display("FAIL b2b_first_start: got %b expected 0", txd_a); end
        tests++; if (level_a !== 3'd1) begin failed++; $display("FAIL b2b_level_1: got %0d expected 1", level_a); end
        k = 0;
        while (level_a !== 3'd0 && k < 3 * FRAME_A) begin
            @(negedge clk);
            k++;
        end
        tests++; if (cyc - s1 !== FRAME_A) begin failed++; $display("FAIL b2b_level_0_time: got %0d cycles expected %0d", cyc - s1, FRAME_A); end
        wait_rx(2, 3 * FRAME_A, to);
        tests++; if (to) begin failed++; $display("FAIL b2b_timeout: got %0d frames expected 2", rx_byte.size()); end
        if (!to) begin
            tests++; if (rx_start[1] - rx_start[0] !== FRAME_A || rx_start[0] !== s1) begin
                failed++; $display("FAIL b2b_spacing: got %0d cycles expected %0d", rx_start[1] - rx_start[0], FRAME_A);
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                r = rx_byte.pop_front();
                ok = rx_ok.pop_front();
                void'(rx_par.pop_front());
                void'(rx_start.pop_front());
                tests++; if (r !== e || !ok) begin failed++; $display("FAIL b2b_byte: got %02h ok=%0d expected %02h ok=1", r, ok, e); end
            end
        end
        exp_q.delete();
        wait_idle_a();
    endtask

    task automatic test_full();
        bit to;
        logic [7:0] e, r;
        bit ok;
        int unsigned prev;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            valid_a = 1'b1;
            data_a  = 8'h10 + 8'(i);
            tests++; if (ready_a !== (i < 5)) begin failed++; $display("FAIL full_ready: offer %0d got %b expected %b", i, ready_a, (i < 5)); end
            if (i < 5) exp_q.push_back(8'h10 + 8'(i));
            if (i == 5) begin
                tests++; if (level_a !== 3'd4) begin failed++; $display("FAIL full_level: got %0d expected 4", level_a); end
            end
        end
        release_a();
        wait_rx(5, 7 * FRAME_A, to);
        tests++; if (to) begin failed++; $display("FAIL full_timeout: got %0d frames expected 5", rx_byte.size()); end
        prev = 0;
        for (int i = 0; !to && i < 5; i++) begin
            e = exp_q.pop_front();
            r = rx_byte.pop_front();
            ok = rx_ok.pop_front();
            void'(rx_par.pop_front());
            tests++; if (r !== e || !ok) begin failed++; $display("FAIL full_byte: frame %0d got %02h ok=%0d expected %02h ok=1", i, r, ok, e); end
            if (i > 0) begin
                tests++; if (rx_start[0] - prev !== FRAME_A) begin failed++; $display("FAIL full_spacing: frame %0d got %0d expected %0d", i, rx_start[0] - prev, FRAME_A); end
            end
            prev = rx_start.pop_front();
        end
        exp_q.delete();
        wait_idle_a();
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        bit to;
        offer_a(8'h07, 1'b1);
        offer_a(8'h03, 1'b1);
        release_a();
        wait_rx(2, 3 * FRAME_A, to);
        tests++; if (to) begin failed++; $display("FAIL parity_timeout: got %0d frames expected 2", rx_byte.size()); end
        if (!to) begin
            tests++; if (rx_byte[0] !== 8'h07 || rx_par[0] !== 1'b1) begin failed++; $display("FAIL parity_07: got %02h par=%b expected 07 par=1", rx_byte[0], rx_par[0]); end
            tests++; if (rx_byte[1] !== 8'h03 || rx_par[1] !== 1'b0) begin failed++; $display("FAIL parity_03: got %02h par=%b expected 03 par=0", rx_byte[1], rx_par[1]); end
            tests++; if (rx_start[1] - rx_start[0] !== 11 * DIV_A) begin failed++; $display("FAIL parity_frame_len: got %0d expected %0d", rx_start[1] - rx_start[0], 11 * DIV_A); end
            tests++; if (!rx_ok[0] || !rx_ok[1]) begin failed++; $display("FAIL parity_frame_ok: got %b%b expected 11", rx_ok[0], rx_ok[1]); end
        end
        rx_byte.delete(); rx_start.delete(); rx_ok.delete(); rx_par.delete();
        exp_q.delete();
        wait_idle_a();
    endtask
`endif

    task automatic test_reset_mid();
        int unsigned s, target;
        int k, lows;
        bit to;
        logic [7:0] e, r;
        bit ok;
        offer_a(8'hFF, 1'b0);
        offer_a(8'h01, 1'b0);
        offer_a(8'h02, 1'b0);
        release_a();
        s = cyc - 1;
        target = s + 4 * DIV_A + DIV_A / 2;
        k = 0;
        while (cyc < target && k < 2 * FRAME_A) begin
            @(negedge clk);
            k++;
        end
        tests++; if (level_a !== 3'd2) begin failed++; $display("FAIL rstmid_level_before: got %0d expected 2", level_a); end
        rst_a = 1'b0;
        #1;
        tests++; if (txd_a !== 1'b1) begin failed++; $display("FAIL rstmid_txd: got %b expected 1", txd_a); end
        tests++; if (level_a !== 3'd0) begin failed++; $display("FAIL rstmid_level: got %0d expected 0", level_a); end
        tests++; if (busy_a !== 1'b0) begin failed++; $display("FAIL rstmid_busy: got %b expected 0", busy_a); end
        tests++; if (ready_a !== 1'b1) begin failed++; $display("FAIL rstmid_ready: got %b expected 1", ready_a); end
        @(negedge clk);
        rst_a = 1'b1;
        lows = 0;
        for (int i = 0; i < FRAME_A + DIV_A; i++) begin
            @(negedge clk);
            if (txd_a !== 1'b1) lows++;
        end
        tests++; if (lows != 0 || rx_byte.size() != 0) begin failed++; $display("FAIL rstmid_quiet: got %0d low cycles, %0d frames expected 0, 0", lows, rx_byte.size()); end
        offer_a(8'h5A, 1'b1);
        release_a();
        wait_rx(1, 2 * FRAME_A, to);
        tests++; if (to) begin failed++; $display("FAIL rstmid_recover_timeout: got 0 frames expected 1"); end
        while (!to && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            r = rx_byte.pop_front();
            ok = rx_ok.pop_front();
            void'(rx_par.pop_front());
            void'(rx_start.pop_front());
            tests++; if (r !== e || !ok) begin failed++; $display("FAIL rstmid_recover_byte: got %02h ok=%0d expected %02h ok=1", r, ok, e); end
        end
        exp_q.delete();
        wait_idle_a();
    endtask

    initial begin
        test_reset();
        test_single();
        test_min_div();
        test_back_to_back();
        test_full();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
